// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end for the bit-serial pattern detectors.
// One active shift word plus a one-word hold register for zero-gap streaming.
module seq_bit_serializer #(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              bit_en,
    output logic              out_bit,
    output logic              out_valid,
    output logic              word_done,
    output logic              busy
);

    localparam int CW = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] hold_reg;
    logic [DATA_W-1:0] shift_nxt;
    logic              hold_full;
    logic [CW-1:0]     bit_cnt;
    logic              head;
    logic              accept;
    logic              last;

    // Output end of the shift register depends on bit order.
    if (MSB_FIRST) begin : g_msb
        assign head      = shift_reg[DATA_W-1];
        assign shift_nxt = {shift_reg[DATA_W-2:0], 1'b0};
    end else begin : g_lsb
        assign head      = shift_reg[0];
        assign shift_nxt = {1'b0, shift_reg[DATA_W-1:1]};
    end

    assign in_ready  = !hold_full;
    assign accept    = in_valid && !hold_full;
    assign last      = (state == SHIFT) && bit_en && (bit_cnt == LAST);
    assign busy      = (state == SHIFT) || hold_full;
    assign out_valid = (state == SHIFT);
    assign out_bit   = (state == SHIFT) ? head : IDLE_BIT;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            hold_reg  <= '0;
            hold_full <= 1'b0;
            bit_cnt   <= '0;
            word_done <= 1'b0;
        end else begin
            word_done <= last;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        shift_reg <= in_data;
                        bit_cnt   <= '0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (last) begin
                        bit_cnt <= '0;
                        if (hold_full) begin
                            shift_reg <= hold_reg;
                            hold_full <= 1'b0;
                        end else if (accept) begin
                            shift_reg <= in_data;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        if (bit_en) begin
                            shift_reg <= shift_nxt;
                            bit_cnt   <= bit_cnt + CW'(1);
                        end
                        if (accept) begin
                            hold_reg  <= in_data;
                            hold_full <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Directed bench for seq_bit_serializer: MSB-first/idle-0 and
// LSB-first/idle-1 instances on a shared clock and reset.
module tb_seq_bit_serializer;

    logic       clk;
    logic       rst;

    logic [7:0] a_data;
    logic       a_valid;
    logic       a_ready;
    logic       a_en;
    logic       a_bit;
    logic       a_ov;
    logic       a_done;
    logic       a_busy;

    logic [7:0] b_data;
    logic       b_valid;
    logic       b_ready;
    logic       b_en;
    logic       b_bit;
    logic       b_ov;
    logic       b_done;
    logic       b_busy;

    int n_pass;
    int n_tot;

    seq_bit_serializer #(
        .DATA_W   (8),
        .MSB_FIRST(1'b1),
        .IDLE_BIT (1'b0)
    ) u_a (
        .clk      (clk),
        .rst      (rst),
        .in_data  (a_data),
        .in_valid (a_valid),
        .in_ready (a_ready),
        .bit_en   (a_en),
        .out_bit  (a_bit),
        .out_valid(a_ov),
        .word_done(a_done),
        .busy     (a_busy)
    );

    seq_bit_serializer #(
        .DATA_W   (8),
        .MSB_FIRST(1'b0),
        .IDLE_BIT (1'b1)
    ) u_b (
        .clk      (clk),
        .rst      (rst),
        .in_data  (b_data),
        .in_valid (b_valid),
        .in_ready (b_ready),
        .bit_en   (b_en),
        .out_bit  (b_bit),
        .out_valid(b_ov),
        .word_done(b_done),
        .busy     (b_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        n_tot++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a_reset(input string tag);
        check({tag, ".bit"}, 16'(a_bit), 16'd0);
        check({tag, ".ov"}, 16'(a_ov), 16'd0);
        check({tag, ".rdy"}, 16'(a_ready), 16'd1);
        check({tag, ".busy"}, 16'(a_busy), 16'd0);
        check({tag, ".done"}, 16'(a_done), 16'd0);
    endtask

    logic [15:0] pat;
    logic [7:0]  w;

    initial begin
        n_pass  = 0;
        n_tot   = 0;
        rst     = 1'b0;
        a_data  = '0;
        a_valid = 1'b0;
        a_en    = 1'b1;
        b_data  = '0;
        b_valid = 1'b0;
        b_en    = 1'b1;

        #3;
        check_a_reset("rst0");
        check("rst0.b_bit", 16'(b_bit), 16'd1);
        check("rst0.b_ov", 16'(b_ov), 16'd0);
        tick();
        rst = 1'b1;
        tick();
        check_a_reset("idle");

        // single word 0x92
        a_data  = 8'h92;
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        a_data  = 8'hFF;
        w = 8'h92;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
            check($sformatf("single.bit%0d", i), 16'(a_bit), 16'(w[7-i]));
            check($sformatf("single.ov%0d", i), 16'(a_ov), 16'd1);
        end
        check("single.busy", 16'(a_busy), 16'd1);
        check("single.rdy", 16'(a_ready), 16'd1);
        check("single.done_early", 16'(a_done), 16'd0);
        tick();
        check("single.done", 16'(a_done), 16'd1);
        check("single.ov_end", 16'(a_ov), 16'd0);
        check("single.bit_end", 16'(a_bit), 16'd0);
        tick();
        check("single.done_clr", 16'(a_done), 16'd0);

        // back-to-back 0xD0, 0x2B
        pat     = 16'hD02B;
        a_data  = 8'hD0;
        a_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (i == 0) a_data = 8'h2B;
            if (i == 1) begin
                a_valid = 1'b0;
                a_data  = 8'h00;
            end
            check($sformatf("b2b.bit%0d", i), 16'(a_bit), 16'(pat[15-i]));
            check($sformatf("b2b.ov%0d", i), 16'(a_ov), 16'd1);
            if (i == 4) begin
                check("b2b.rdy_full", 16'(a_ready), 16'd0);
                check("b2b.busy", 16'(a_busy), 16'd1);
                check("b2b.done_mid", 16'(a_done), 16'd0);
            end
            if (i == 8) begin
                check("b2b.done1", 16'(a_done), 16'd1);
                check("b2b.rdy_free", 16'(a_ready), 16'd1);
            end
        end
        tick();
        check("b2b.done2", 16'(a_done), 16'd1);
        check("b2b.ov_end", 16'(a_ov), 16'd0);
        tick();

        // paced 0xA5, second word 0x3C loaded while bit_en=0
        w       = 8'hA5;
        a_en    = 1'b0;
        a_data  = 8'hA5;
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        for (int j = 0; j < 16; j++) begin
            check($sformatf("pace.bit%0d", j), 16'(a_bit), 16'(w[7-j/2]));
            check($sformatf("pace.ov%0d", j), 16'(a_ov), 16'd1);
            a_en = (j % 2 == 1);
            if (j == 2) begin
                a_data  = 8'h3C;
                a_valid = 1'b1;
            end
            tick();
            if (j == 2) begin
                a_valid = 1'b0;
                check("pace.hold_rdy", 16'(a_ready), 16'd0);
                check("pace.hold_busy", 16'(a_busy), 16'd1);
            end
        end
        a_en = 1'b1;
        w = 8'h3C;
        check("pace.handoff_done", 16'(a_done), 16'd1);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) tick();
            check($sformatf("pace2.bit%0d", k), 16'(a_bit), 16'(w[7-k]));
            check($sformatf("pace2.ov%0d", k), 16'(a_ov), 16'd1);
        end
        tick();
        check("pace2.done", 16'(a_done), 16'd1);
        check("pace2.ov_end", 16'(a_ov), 16'd0);
        tick();

        // LSB-first 0x01 with idle level 1
        check("lsb.idle_bit", 16'(b_bit), 16'd1);
        b_data  = 8'h01;
        b_valid = 1'b1;
        tick();
        b_valid = 1'b0;
        w = 8'h01;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
            check($sformatf("lsb.bit%0d", i), 16'(b_bit), 16'(w[i]));
            check($sformatf("lsb.ov%0d", i), 16'(b_ov), 16'd1);
        end
        tick();
        check("lsb.done", 16'(b_done), 16'd1);
        check("lsb.ov_end", 16'(b_ov), 16'd0);
        check("lsb.idle_end", 16'(b_bit), 16'd1);
        tick();

        // reset mid-word with a held word
        a_data  = 8'hFF;
        a_valid = 1'b1;
        tick();
        a_data = 8'h55;
        tick();
        a_valid = 1'b0;
        check("mid.held", 16'(a_ready), 16'd0);
        tick();
        tick();
        check("mid.bit3", 16'(a_bit), 16'd1);
        a_valid = 1'b1;
        a_data  = 8'h12;
        #2;
        rst = 1'b0;
        #1;
        check_a_reset("mid.rst");
        tick();
        check_a_reset("mid.rst_hold");
        a_valid = 1'b0;
        rst = 1'b1;
        tick();
        check_a_reset("mid.released");
        w       = 8'h80;
        a_data  = 8'h80;
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
            check($sformatf("post.bit%0d", i), 16'(a_bit), 16'(w[7-i]));
            check($sformatf("post.ov%0d", i), 16'(a_ov), 16'd1);
        end
        tick();
        check("post.done", 16'(a_done), 16'd1);
        check("post.ov_end", 16'(a_ov), 16'd0);
        check("post.busy_end", 16'(a_busy), 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/seq_bit_serializer.md
Name: seq_bit_serializer

Overview:
Parallel-to-serial front end for the bit-serial pattern detectors. It accepts DATA_W-bit words over a valid/ready handshake and emits them one bit per enabled clock on out_bit, which drives the detector's single-bit `in` input. A one-word hold register allows back-to-back words with no idle gap. When no word is active it drives a fixed idle level.

Parameters:
DATA_W, 8, word width in bits (>=2)
MSB_FIRST, 1, 1 = emit bit DATA_W-1 first; 0 = emit bit 0 first
IDLE_BIT, 0, level driven on out_bit while no word is active

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low
in_data  input  DATA_W  word to serialize
in_valid  input  1  in_data valid
in_ready  output  1  block can accept a word this cycle
bit_en  input  1  bit-advance strobe for rate pacing; tie to 1 for one bit per clock
out_bit  output  1  serial bit to the detector
out_valid  output  1  out_bit carries word data (not idle fill)
word_done  output  1  one-cycle pulse, registered, after the last bit of a word is consumed
busy  output  1  active word or held word present

Behaviour:
- Reset (rst=0, async): state=IDLE, shift/hold registers=0, hold_full=0, bit_cnt=0.
- Reset output values: out_bit=IDLE_BIT, out_valid=0, in_ready=1, word_done=0, busy=0.
- A word is accepted on a rising edge when in_valid=1 and in_ready=1.
- in_ready = !hold_full. It depends only on registered state, with no combinational path from any input.
- States:
  - IDLE: out_valid=0, out_bit=IDLE_BIT. On accept, load in_data into shift_reg, set bit_cnt=0, go to SHIFT.
  - SHIFT: out_valid=1. out_bit = shift_reg[DATA_W-1] if MSB_FIRST, else shift_reg[0].
- Latency: a word accepted at edge N shows its first bit from just after edge N. There is no extra pipeline stage, and out_bit/out_valid are decoded from registers only.
- Bit advance in SHIFT: on each edge with bit_en=1, shift toward the output end and increment bit_cnt. With bit_en=0, out_bit, shift_reg and bit_cnt all hold.
- Last bit: the edge with bit_en=1 and bit_cnt=DATA_W-1 consumes the last bit. On that edge:
  - hold_full=1: move hold to shift_reg, clear hold_full, bit_cnt=0, stay in SHIFT (zero-gap handoff).
  - hold_full=0 and an accept on the same edge: load in_data directly into shift_reg, stay in SHIFT (zero gap).
  - Otherwise: go to IDLE.
  - In all cases, word_done=1 for the following cycle.
- Accept while in SHIFT and not on the last-bit edge: in_data goes to hold, hold_full=1.
- Simultaneous last-bit edge with hold_full=1: in_ready is already 0, so no accept is possible. The hold register is freed and in_ready=1 next cycle.
- Loading is independent of bit_en. Words can be accepted while bit_en=0.
- busy = (state==SHIFT) or hold_full.
- bit_cnt width = $clog2(DATA_W). It never exceeds DATA_W-1.
- Reset asserted mid-word: the active and held words are discarded immediately and outputs take reset values. After release, the next accepted word starts at bit 0.
- in_data is ignored when the handshake does not complete. in_valid may drop without a transfer.

Test Plan:
- Reset: assert rst=0 mid-sim with in_valid=1 -> out_bit=0, out_valid=0, in_ready=1, busy=0, word_done=0 immediately (asynchronous, before the next edge).
- Single word: DATA_W=8, MSB_FIRST=1, bit_en=1, accept 0x92 at edge N -> out_bit=1,0,0,1,0,0,1,0 over cycles N..N+7 with out_valid=1. word_done=1 in cycle N+8, then out_valid=0 and out_bit=0.
- Back-to-back: in_valid held high with 0xD0 then 0x2B -> 16 contiguous out_valid=1 bits 11010000 00101011, no idle gap. in_ready=0 while the hold register is full. word_done pulses twice, 8 cycles apart.
- Pacing: bit_en alternating 1,0 with word 0xA5 -> each bit visible for 2 cycles and the word spans 16 cycles. A second word accepted while bit_en=0 lands in hold.
- LSB-first: MSB_FIRST=0, word 0x01 -> out_bit=1,0,0,0,0,0,0,0. With IDLE_BIT=1, out_bit=1 while in IDLE.
- Reset mid-operation: rst=0 after bit 3 of 0xFF with a word held -> both words dropped. After release, accept 0x80 -> out_bit sequence starts 1,0,0... from bit 0.
